// File: rtl/seq_mult.sv
// seq_mult: a sequential shift-add multiplier with a start/done handshake.
// It multiplies two WIDTH-bit operands over WIDTH iteration cycles and
// produces a 2*WIDTH-bit product.
//
// Optional feature macro: SEQ_MULT_SIGNED_EN
//   defined   : signed_mode selects two's-complement operands and product.
//   undefined : signed_mode is ignored and every operation is unsigned.
//
// Ports:
//   clk         rising-edge system clock
//   rst         synchronous, active-high reset
//   start       request; sampled only in IDLE
//   mcand       multiplicand, captured on an accepted start
//   mplier      multiplier, captured on an accepted start
//   signed_mode 1 = two's-complement operation (captured on an accepted start)
//   busy        high whenever the state is not IDLE
//   done        one-cycle pulse; product is valid in that cycle
//   product     result register; holds its value until the next done
module seq_mult #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  input  logic               signed_mode,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    mcand_sh;
  logic [WIDTH-1:0] mplier_sh;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand_mag;
  logic [WIDTH-1:0] mplier_mag;
  logic [PW-1:0]    product_next;
  logic             last_iter;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg;
  logic neg_in;

  // Operand magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) as an unsigned value.
  always_comb begin
    mcand_mag  = mcand;
    mplier_mag = mplier;
    neg_in     = 1'b0;
    if (signed_mode) begin
      if (mcand[WIDTH-1]) mcand_mag = WIDTH'(~mcand + 1'b1);
      if (mplier[WIDTH-1]) mplier_mag = WIDTH'(~mplier + 1'b1);
      neg_in = mcand[WIDTH-1] ^ mplier[WIDTH-1];
    end
  end

  // Final sign fix-up; negating zero yields zero, so no special case needed.
  always_comb begin
    product_next = acc_next;
    if (neg) product_next = PW'(~acc_next + 1'b1);
  end
`else
  logic unused_signed_mode;

  assign unused_signed_mode = signed_mode;

  always_comb begin
    mcand_mag    = mcand;
    mplier_mag   = mplier;
    product_next = acc_next;
  end
`endif

  // One shift-add step: the multiplicand is pre-shifted so it always sits at
  // the weight of the multiplier bit currently in position 0.
  always_comb begin
    acc_next = acc;
    if (mplier_sh[0]) acc_next = acc + mcand_sh;
  end

  assign last_iter = (cnt == CW'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and registered outputs. The product and done are loaded on the
  // edge that enters DONE so both are visible during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
      cnt       <= '0;
      product   <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= '0;
            mcand_sh  <= PW'(mcand_mag);
            mplier_sh <= mplier_mag;
            cnt       <= CW'(WIDTH);
`ifdef SEQ_MULT_SIGNED_EN
            neg       <= neg_in;
`endif
          end
        end
        RUN: begin
          acc       <= acc_next;
          mcand_sh  <= mcand_sh << 1;
          mplier_sh <= mplier_sh >> 1;
          cnt       <= cnt - 1'b1;
          if (last_iter) begin
            product <= product_next;
            done    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: stimulus pushes expected product and done
// cycle into per-instance queues; monitors pop and compare on each done.
module tb_seq_mult;

  localparam int unsigned W4 = 4;
  localparam int unsigned W8 = 8;

  logic clk = 1'b0;
  logic rst;

  logic          start4, sm4, busy4, done4;
  logic [3:0]    mcand4, mplier4;
  logic [7:0]    product4;
  logic          start8, sm8, busy8, done8;
  logic [7:0]    mcand8, mplier8;
  logic [15:0]   product8;

  typedef struct {
    logic [15:0] prod;
    int          cyc;
  } exp_t;

  exp_t q4[$];
  exp_t q8[$];
  exp_t e4, e8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic prev_done4 = 1'b0;
  logic prev_done8 = 1'b0;

`ifdef SEQ_MULT_SIGNED_EN
  localparam logic [7:0] E_M8M8 = 8'h40;
  localparam logic [7:0] E_M8P7 = 8'hC8;
  localparam logic [7:0] E_3M5  = 8'hF1;
`else
  localparam logic [7:0] E_M8M8 = 8'h40;
  localparam logic [7:0] E_M8P7 = 8'h38;
  localparam logic [7:0] E_3M5  = 8'h21;
`endif

  seq_mult #(.WIDTH(W4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .mcand(mcand4), .mplier(mplier4),
    .signed_mode(sm4), .busy(busy4), .done(done4), .product(product4)
  );

  seq_mult #(.WIDTH(W8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .mcand(mcand8), .mplier(mplier8),
    .signed_mode(sm8), .busy(busy8), .done(done8), .product(product8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the WIDTH=4 instance.
  always @(negedge clk) begin
    if (done4) begin
      chk("done4_not_back_to_back", 32'(prev_done4), 32'd0);
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done4_unexpected: product %h with no pending request (cycle %0d)", product4, cyc);
      end else begin
        e4 = q4.pop_front();
        chk("product4", 32'(product4), 32'(e4.prod));
        chk("done4_cycle", 32'(cyc), 32'(e4.cyc));
      end
    end
    prev_done4 = done4;
  end

  // Monitor for the WIDTH=8 instance.
  always @(negedge clk) begin
    if (done8) begin
      chk("done8_not_back_to_back", 32'(prev_done8), 32'd0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected: product %h with no pending request (cycle %0d)", product8, cyc);
      end else begin
        e8 = q8.pop_front();
        chk("product8", 32'(product8), 32'(e8.prod));
        chk("done8_cycle", 32'(cyc), 32'(e8.cyc));
      end
    end
    prev_done8 = done8;
  end

  // Called at a negedge; start is sampled by the following rising edge.
  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic [7:0] exp, input bit push);
    mcand4  = a;
    mplier4 = b;
    sm4     = s;
    start4  = 1'b1;
    if (push) q4.push_back('{16'(exp), cyc + int'(W4) + 1});
    @(negedge clk);
    start4  = 1'b0;
    mcand4  = 4'($urandom);
    mplier4 = 4'($urandom);
    sm4     = 1'($urandom);
    chk("busy4_after_start", 32'(busy4), 32'd1);
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    mcand8  = a;
    mplier8 = b;
    sm8     = 1'b0;
    start8  = 1'b1;
    q8.push_back('{exp, cyc + int'(W8) + 1});
    @(negedge clk);
    start8  = 1'b0;
    mcand8  = 8'($urandom);
    mplier8 = 8'($urandom);
    chk("busy8_after_start", 32'(busy8), 32'd1);
  endtask

  task automatic wait_idle4(input int exp_cyc);
    int n = 0;
    while (busy4 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy4) begin
      checks++;
      errors++;
      $display("FAIL idle4_timeout: busy still 1 after %0d cycles", n);
    end else begin
      chk("idle4_cycle", 32'(cyc), 32'(exp_cyc));
    end
  endtask

  task automatic wait_idle8(input int exp_cyc);
    int n = 0;
    while (busy8 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy8) begin
      checks++;
      errors++;
      $display("FAIL idle8_timeout: busy still 1 after %0d cycles", n);
    end else begin
      chk("idle8_cycle", 32'(cyc), 32'(exp_cyc));
    end
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    start4 = 1'b0; mcand4 = '0; mplier4 = '0; sm4 = 1'b0;
    start8 = 1'b0; mcand8 = '0; mplier8 = '0; sm8 = 1'b0;
    repeat (3) @(negedge clk);

    // rst and start together: the request must be dropped.
    start4 = 1'b1; mcand4 = 4'd3; mplier4 = 4'd3;
    @(negedge clk);
    rst = 1'b0; start4 = 1'b0;
    chk("reset_busy4", 32'(busy4), 32'd0);
    chk("reset_done4", 32'(done4), 32'd0);
    chk("reset_product4", 32'(product4), 32'd0);
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_product8", 32'(product8), 32'd0);
    @(negedge clk);
    chk("rst_start_dropped", 32'(busy4), 32'd0);

    // 15*15 unsigned with full handshake timing.
    n0 = cyc;
    issue4(4'hF, 4'hF, 1'b0, 8'hE1, 1'b1);
    wait_idle4(n0 + 6);
    chk("product4_hold", 32'(product4), 32'hE1);

    // Signed vectors (unsigned interpretation when the feature is off).
    n0 = cyc; issue4(4'h8, 4'h8, 1'b1, E_M8M8, 1'b1); wait_idle4(n0 + 6);
    n0 = cyc; issue4(4'h8, 4'h7, 1'b1, E_M8P7, 1'b1); wait_idle4(n0 + 6);
    n0 = cyc; issue4(4'h3, 4'hB, 1'b1, E_3M5, 1'b1);  wait_idle4(n0 + 6);

    // Zero operands, including a negative partner in signed mode.
    n0 = cyc; issue4(4'h0, 4'h9, 1'b0, 8'h00, 1'b1); wait_idle4(n0 + 6);
    n0 = cyc; issue4(4'hD, 4'h0, 1'b1, 8'h00, 1'b1); wait_idle4(n0 + 6);
    n0 = cyc; issue4(4'h8, 4'h7, 1'b0, 8'h38, 1'b1); wait_idle4(n0 + 6);

    // Start pulsed mid-RUN with different operands is ignored.
    n0 = cyc;
    issue4(4'h6, 4'h7, 1'b0, 8'h2A, 1'b1);
    start4 = 1'b1; mcand4 = 4'hF; mplier4 = 4'hF;
    @(negedge clk);
    start4 = 1'b0;
    wait_idle4(n0 + 6);
    repeat (3) @(negedge clk);

    // Start held high: accepted every WIDTH+2 cycles.
    n0 = cyc;
    mcand4 = 4'h3; mplier4 = 4'h5; sm4 = 1'b0; start4 = 1'b1;
    q4.push_back('{16'h000F, n0 + 5});
    q4.push_back('{16'h000F, n0 + 11});
    q4.push_back('{16'h000F, n0 + 17});
    repeat (13) @(negedge clk);
    start4 = 1'b0;
    wait_idle4(n0 + 18);

    // Reset mid-RUN: no done, product cleared.
    n0 = cyc;
    issue4(4'h5, 4'h5, 1'b0, 8'h19, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_rst_busy4", 32'(busy4), 32'd0);
    chk("midrun_rst_product4", 32'(product4), 32'd0);
    chk("midrun_rst_done4", 32'(done4), 32'd0);
    repeat (6) @(negedge clk);
    n0 = cyc; issue4(4'h2, 4'h3, 1'b0, 8'h06, 1'b1); wait_idle4(n0 + 6);

    // WIDTH=8 instance.
    n0 = cyc; issue8(8'hFF, 8'hFF, 16'hFE01); wait_idle8(n0 + 10);
    n0 = cyc; issue8(8'h80, 8'h80, 16'h4000); wait_idle8(n0 + 10);

    repeat (5) @(negedge clk);
    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
